// File: rtl/cordic_arbiter_if.sv
// cordic_arbiter_if
//   Bundles the requester, CORDIC-core and response signals of cordic_arbiter.
//   slave  : the arbiter's view (requests/core results in, grants/issue/results out)
//   master : the surrounding datapath's view (requesters, core and result sinks)
//   req_*      : per-requester packed valid/lock/mode/operands, requester i at slot i
//   cordic_*   : registered issue to the core and the core's result return
//   rsp_*      : registered one-hot result strobe plus shared result bus
//   busy       : lock held or any operation in flight
//   tag_err    : sticky core-valid vs tag-pipe disagreement
interface cordic_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int CORDIC_WIDTH = 22,
    parameter int ANGLE_WIDTH  = 16
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ-1:0]              req_lock;
    logic [NUM_REQ-1:0]              req_mode;
    logic [NUM_REQ*CORDIC_WIDTH-1:0] req_x;
    logic [NUM_REQ*CORDIC_WIDTH-1:0] req_y;
    logic [NUM_REQ*ANGLE_WIDTH-1:0]  req_angle;

    logic                            cordic_in_valid;
    logic                            cordic_mode;
    logic [CORDIC_WIDTH-1:0]         cordic_x;
    logic [CORDIC_WIDTH-1:0]         cordic_y;
    logic [ANGLE_WIDTH-1:0]          cordic_angle;
    logic                            cordic_out_valid;
    logic [CORDIC_WIDTH-1:0]         cordic_x_out;
    logic [CORDIC_WIDTH-1:0]         cordic_y_out;
    logic [ANGLE_WIDTH-1:0]          cordic_angle_out;

    logic [NUM_REQ-1:0]              rsp_valid;
    logic [CORDIC_WIDTH-1:0]         rsp_x;
    logic [CORDIC_WIDTH-1:0]         rsp_y;
    logic [ANGLE_WIDTH-1:0]          rsp_angle;
    logic                            busy;
    logic                            tag_err;

    modport slave (
        input  req_valid, req_lock, req_mode, req_x, req_y, req_angle,
        input  cordic_out_valid, cordic_x_out, cordic_y_out, cordic_angle_out,
        output req_ready,
        output cordic_in_valid, cordic_mode, cordic_x, cordic_y, cordic_angle,
        output rsp_valid, rsp_x, rsp_y, rsp_angle, busy, tag_err
    );

    modport master (
        output req_valid, req_lock, req_mode, req_x, req_y, req_angle,
        output cordic_out_valid, cordic_x_out, cordic_y_out, cordic_angle_out,
        input  req_ready,
        input  cordic_in_valid, cordic_mode, cordic_x, cordic_y, cordic_angle,
        input  rsp_valid, rsp_x, rsp_y, rsp_angle, busy, tag_err
    );
endinterface

// File: rtl/cordic_arbiter.sv
// cordic_arbiter
//   Shares one fully pipelined CORDIC core among NUM_REQ requesters.
//   Round-robin grant with an optional per-beat lock that holds the core for a
//   burst; every issued op carries its requester id down a tag pipe matched to
//   the core latency so the result is routed back to its originator.
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset
//   io_bus : cordic_arbiter_if.slave (requests, core issue/return, responses,
//            busy, tag_err)
module cordic_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int CORDIC_WIDTH  = 22,
    parameter int ANGLE_WIDTH   = 16,
    parameter int CORDIC_STAGES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    cordic_arbiter_if.slave   io_bus
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [IDW-1:0]            r_rr_ptr;
    logic [IDW-1:0]            r_owner;
    logic [IDW-1:0]            w_grant_id;
    logic                      w_found;
    logic                      w_xfer;
    logic [NUM_REQ-1:0]        w_ready;
    int unsigned               w_idx;

    logic                      w_sel_mode;
    logic [CORDIC_WIDTH-1:0]   w_sel_x;
    logic [CORDIC_WIDTH-1:0]   w_sel_y;
    logic [ANGLE_WIDTH-1:0]    w_sel_angle;

    logic                      r_in_valid;
    logic                      r_mode;
    logic [CORDIC_WIDTH-1:0]   r_x;
    logic [CORDIC_WIDTH-1:0]   r_y;
    logic [ANGLE_WIDTH-1:0]    r_angle;
    logic [IDW-1:0]            r_issue_id;

    logic [CORDIC_STAGES-1:0]  r_tag_v;
    logic [IDW-1:0]            r_tag_id [CORDIC_STAGES];
    logic                      w_head_v;
    logic [IDW-1:0]            w_head_id;
    logic                      w_tag_mis;
    logic                      w_accept;

    logic [NUM_REQ-1:0]        r_rsp_valid;
    logic [CORDIC_WIDTH-1:0]   r_rsp_x;
    logic [CORDIC_WIDTH-1:0]   r_rsp_y;
    logic [ANGLE_WIDTH-1:0]    r_rsp_angle;
    logic                      r_tag_err;

    // Grant selection and next state. In IDLE the search starts one past the
    // last granted requester; in LOCKED only the owner can be accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_found     = 1'b0;
        w_grant_id  = '0;
        w_idx       = 0;
        case (r_state)
            S_IDLE: begin
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    w_idx = 32'(r_rr_ptr) + 1 + k;
                    if (w_idx >= NUM_REQ) begin
                        w_idx = w_idx - NUM_REQ;
                    end
                    if (!w_found && io_bus.req_valid[IDW'(w_idx)]) begin
                        w_found    = 1'b1;
                        w_grant_id = IDW'(w_idx);
                    end
                end
                if (w_found && io_bus.req_lock[w_grant_id]) begin
                    w_state_nxt = S_LOCKED;
                end
            end
            S_LOCKED: begin
                w_grant_id = r_owner;
                w_found    = io_bus.req_valid[r_owner];
                if (w_found && !io_bus.req_lock[r_owner]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Ready must stay low for the whole time reset is asserted.
        w_xfer  = w_found && !i_rst;
        w_ready = w_xfer ? (NUM_REQ'(1) << w_grant_id) : '0;
    end

    always_comb begin
        w_sel_mode  = 1'b0;
        w_sel_x     = '0;
        w_sel_y     = '0;
        w_sel_angle = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == w_grant_id) begin
                w_sel_mode  = io_bus.req_mode[IDW'(i)];
                w_sel_x     = io_bus.req_x[i*CORDIC_WIDTH +: CORDIC_WIDTH];
                w_sel_y     = io_bus.req_y[i*CORDIC_WIDTH +: CORDIC_WIDTH];
                w_sel_angle = io_bus.req_angle[i*ANGLE_WIDTH +: ANGLE_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= IDW'(NUM_REQ - 1);
            r_owner    <= '0;
            r_in_valid <= 1'b0;
            r_mode     <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_angle    <= '0;
            r_issue_id <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_valid <= w_xfer;
            if (w_xfer) begin
                r_rr_ptr   <= w_grant_id;
                r_mode     <= w_sel_mode;
                r_x        <= w_sel_x;
                r_y        <= w_sel_y;
                r_angle    <= w_sel_angle;
                r_issue_id <= w_grant_id;
            end
            if (w_state_nxt == S_LOCKED) begin
                r_owner <= w_grant_id;
            end
        end
    end

    // The tag pipe is fed from the issue register, so the head lines up with
    // the core output CORDIC_STAGES cycles after cordic_in_valid.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tag_v <= '0;
            for (int unsigned i = 0; i < CORDIC_STAGES; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_v     <= {r_tag_v[CORDIC_STAGES-2:0], r_in_valid};
            r_tag_id[0] <= r_issue_id;
            for (int unsigned i = 1; i < CORDIC_STAGES; i++) begin
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    assign w_head_v  = r_tag_v[CORDIC_STAGES-1];
    assign w_head_id = r_tag_id[CORDIC_STAGES-1];
    assign w_tag_mis = io_bus.cordic_out_valid != w_head_v;
    assign w_accept  = io_bus.cordic_out_valid && !w_tag_mis;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsp_valid <= '0;
            r_rsp_x     <= '0;
            r_rsp_y     <= '0;
            r_rsp_angle <= '0;
            r_tag_err   <= 1'b0;
        end else begin
            if (w_tag_mis) begin
                r_tag_err <= 1'b1;
            end
            r_rsp_valid <= w_accept ? (NUM_REQ'(1) << w_head_id) : '0;
            if (w_accept) begin
                r_rsp_x     <= io_bus.cordic_x_out;
                r_rsp_y     <= io_bus.cordic_y_out;
                r_rsp_angle <= io_bus.cordic_angle_out;
            end
        end
    end

    assign io_bus.req_ready       = w_ready;
    assign io_bus.cordic_in_valid = r_in_valid;
    assign io_bus.cordic_mode     = r_mode;
    assign io_bus.cordic_x        = r_x;
    assign io_bus.cordic_y        = r_y;
    assign io_bus.cordic_angle    = r_angle;
    assign io_bus.rsp_valid       = r_rsp_valid;
    assign io_bus.rsp_x           = r_rsp_x;
    assign io_bus.rsp_y           = r_rsp_y;
    assign io_bus.rsp_angle       = r_rsp_angle;
    assign io_bus.tag_err         = r_tag_err;
    assign io_bus.busy            = (r_state == S_LOCKED) | (|r_tag_v) | r_in_valid
                                  | (|r_rsp_valid);
endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Shares one fully pipelined CORDIC core among NUM_REQ requesters (GSO unit, normalize unit, update datapath, spare) inside the SICA datapath. Grants are round-robin, with an optional lock that holds the core for a multi-beat burst such as a VECTOR_DIM-element sweep. Each accepted operation is tagged with its requester ID so the result is routed back to the originating unit.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- CORDIC_WIDTH, 22, x/y operand width, signed
- ANGLE_WIDTH, 16, angle width, signed
- CORDIC_STAGES, 16, fixed core latency in cycles, cordic_in_valid to cordic_out_valid
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_lock  in  NUM_REQ  keep grant after this beat
- req_mode  in  NUM_REQ  0 = rotation, 1 = vectoring
- req_x, req_y  in  NUM_REQ*CORDIC_WIDTH  packed operands, requester i at bits [i*CORDIC_WIDTH +: CORDIC_WIDTH]
- req_angle  in  NUM_REQ*ANGLE_WIDTH  packed angles
- cordic_in_valid  out  1  issue to core, registered
- cordic_mode  out  1  registered
- cordic_x, cordic_y  out  CORDIC_WIDTH  registered
- cordic_angle  out  ANGLE_WIDTH  registered
- cordic_out_valid  in  1  core result valid
- cordic_x_out, cordic_y_out  in  CORDIC_WIDTH  core results
- cordic_angle_out  in  ANGLE_WIDTH  core result
- rsp_valid  out  NUM_REQ  one-hot result strobe, registered, no backpressure
- rsp_x, rsp_y  out  CORDIC_WIDTH  shared result bus, registered
- rsp_angle  out  ANGLE_WIDTH  registered
- busy  out  1  lock held or any op in flight
- tag_err  out  1  sticky; core output valid disagrees with the tag pipe

## Operation
- FSM states: S_IDLE and S_LOCKED.
- In S_IDLE, round-robin search starts at rr_ptr+1 (mod NUM_REQ). The first requester with req_valid=1 gets req_ready=1. Only one bit of req_ready may be high, and req_ready is combinational from req_valid.
- A transfer occurs when req_valid[i] and req_ready[i] are both high. On a transfer, rr_ptr <= i.
- If req_lock[i]=1 on a transfer, the FSM moves to S_LOCKED with owner <= i.
- In S_LOCKED, req_ready = req_valid[owner] only; all other requesters are blocked. If the owner's valid is low, no issue occurs (bubble) and the lock holds.
- S_LOCKED -> S_IDLE on an owner transfer with req_lock[owner]=0. That final beat is issued normally.
- Issue: on a transfer, the cycle after it has cordic_in_valid=1 and cordic_mode/x/y/angle = the selected requester's fields. With no transfer, cordic_in_valid=0 and the data fields hold their last values.
- Tag pipe: CORDIC_STAGES-deep shift register of {valid, id}. It loads {cordic_in_valid, granted id} in step with the issue register, so its head aligns with cordic_out_valid.
- Response: when cordic_out_valid=1, the next cycle drives rsp_valid = one-hot(head id) and rsp_x/y/angle = core outputs. The rsp data fields otherwise hold.
- tag_err is set when cordic_out_valid differs from head valid. When tag_err is set, the result is dropped (rsp_valid=0). tag_err clears only on reset.
- busy = (state==S_LOCKED) | any tag-pipe valid | cordic_in_valid | any rsp_valid.
- Data is passed through unmodified; no arithmetic is performed in this block.

## Timing
- Reset values: req_ready=0 while reset is asserted, rr_ptr=NUM_REQ-1 (requester 0 wins first), state=S_IDLE, tag pipe cleared, cordic_in_valid=0, cordic_mode/x/y/angle=0, rsp_valid=0, rsp_x/y/angle=0, busy=0, tag_err=0.
- Latency: transfer at cycle T gives cordic_in_valid at T+1 and rsp_valid at T+CORDIC_STAGES+2.
- Throughput: one transfer per cycle sustained, including back-to-back beats from the same or different requesters.
- Simultaneous requests: exactly one granted per cycle; losers hold valid and data stable (requester obligation).
- A lock asserted by a requester that is not granted is ignored.
- Reset mid-operation: the in-flight tag pipe and any lock are discarded; results are lost. The core shares the same reset, so no stale cordic_out_valid arrives after reset.
- cordic_out_valid with an empty tag pipe sets tag_err.

## Test plan
- Single op: req_valid[2] for one cycle at T with x=100, y=-50 -> cordic_in_valid at T+1 with x=100, y=-50; rsp_valid=4'b0100 at T+18 carrying the core output.
- Contention: req_valid=4'b1111 held after reset -> grant order 0,1,2,3,0 on consecutive cycles; five issues in five cycles.
- Lock burst: requester 1 issues 7 beats with req_lock=1 on beats 1..6 and 0 on beat 7, while requester 3 requests continuously -> requester 3 is blocked until the cycle after beat 7; owner bubbles are respected.
- Throughput: 32 back-to-back beats from requester 0 -> 32 consecutive rsp_valid pulses starting 18 cycles after the first transfer; ids are correct and busy drops one cycle after the last rsp.
- Fault: force cordic_out_valid=1 with the tag pipe empty -> tag_err=1 next cycle and stays high; no rsp_valid pulse.
- Reset mid-flight: 5 ops in flight, assert reset -> all outputs return to reset values immediately; after release, requester 0 is granted first and no stray rsp_valid appears.
